// File: rtl/ecc_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ecc_mem_ctrl
// Brief   : SECDED (13,8) register-file controller with host port and
//           background scrubber. Optional ECC_ERR_INJECT_EN adds inj_mask.
// Revision: 1.0
// ============================================================================
module ecc_mem_ctrl #(
  parameter int ADDR_W         = 4,
  parameter int SCRUB_INTERVAL = 256,
  parameter int CNT_W          = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_wdata,
`ifdef ECC_ERR_INJECT_EN
  input  logic [12:0]       inj_mask,
`endif
  output logic              resp_valid,
  output logic [7:0]        resp_rdata,
  output logic [1:0]        resp_status,
  input  logic              scrub_en,
  output logic              init_done,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt,
  output logic [ADDR_W-1:0] err_addr,
  output logic              err_irq
);

  localparam int c_depth = 2**ADDR_W;
  localparam int c_tmr_w = $clog2(SCRUB_INTERVAL + 1);
  localparam logic [c_tmr_w-1:0] c_tmr_reload = c_tmr_w'(SCRUB_INTERVAL);

  localparam logic [2:0] c_st_init  = 3'd0;
  localparam logic [2:0] c_st_idle  = 3'd1;
  localparam logic [2:0] c_st_write = 3'd2;
  localparam logic [2:0] c_st_read  = 3'd3;
  localparam logic [2:0] c_st_check = 3'd4;
  localparam logic [2:0] c_st_fix   = 3'd5;
  localparam logic [2:0] c_st_resp  = 3'd6;

  function automatic logic [12:0] f_encode(input logic [7:0] d);
    logic [12:0] w;
    w      = '0;
    w[2]   = d[0];
    w[4]   = d[1];
    w[5]   = d[2];
    w[6]   = d[3];
    w[8]   = d[4];
    w[9]   = d[5];
    w[10]  = d[6];
    w[11]  = d[7];
    w[0]   = w[2] ^ w[4] ^ w[6] ^ w[8] ^ w[10];
    w[1]   = w[2] ^ w[5] ^ w[6] ^ w[9] ^ w[10];
    w[3]   = w[4] ^ w[5] ^ w[6] ^ w[11];
    w[7]   = w[8] ^ w[9] ^ w[10] ^ w[11];
    w[12]  = ^w[11:0];
    return w;
  endfunction

  function automatic logic [7:0] f_data(input logic [12:0] w);
    return {w[11], w[10], w[9], w[8], w[6], w[5], w[4], w[2]};
  endfunction

  logic [2:0]         r_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [7:0]         r_wdata;
  logic               r_scrub;
  logic [ADDR_W-1:0]  r_init_ptr;
  logic [ADDR_W-1:0]  r_scrub_ptr;
  logic [c_tmr_w-1:0] r_timer;
  logic               r_init_done;
  logic [CNT_W-1:0]   r_corr_cnt;
  logic [CNT_W-1:0]   r_uncorr_cnt;
  logic [ADDR_W-1:0]  r_err_addr;
  logic               r_err_irq;
  logic [7:0]         r_rdata;
  logic [1:0]         r_status;
  logic [12:0]        r_rdword;
  logic [12:0]        r_mem [c_depth];
  logic [12:0]        r_mask;

  logic [3:0]         w_syn;
  logic               w_op;
  logic               w_corr;
  logic               w_uncorr;
  logic [12:0]        w_fixed;
  logic               w_mem_we;
  logic [ADDR_W-1:0]  w_mem_addr;
  logic [12:0]        w_mem_wdata;

  assign w_syn[3] = ^r_rdword[11:7];
  assign w_syn[2] = r_rdword[3] ^ r_rdword[4] ^ r_rdword[5] ^ r_rdword[6] ^ r_rdword[11];
  assign w_syn[1] = r_rdword[1] ^ r_rdword[2] ^ r_rdword[5] ^ r_rdword[6] ^ r_rdword[9] ^ r_rdword[10];
  assign w_syn[0] = r_rdword[0] ^ r_rdword[2] ^ r_rdword[4] ^ r_rdword[6] ^ r_rdword[8] ^ r_rdword[10];
  assign w_op     = ^r_rdword;
  assign w_corr   = w_op && (w_syn <= 4'd12);
  assign w_uncorr = (w_op && (w_syn > 4'd12)) || (!w_op && (w_syn != 4'd0));

  // Syndrome 0 with odd parity means only the overall parity bit flipped.
  always_comb begin
    w_fixed = r_rdword;
    if (w_op && (w_syn == 4'd0)) w_fixed[12] = ~r_rdword[12];
    for (int i = 0; i < 12; i++) begin
      if (w_op && (w_syn == 4'(i + 1))) w_fixed[i] = ~r_rdword[i];
    end
  end

  assign w_mem_we   = (r_state == c_st_init) || (r_state == c_st_write) || (r_state == c_st_fix);
  assign w_mem_addr = (r_state == c_st_init) ? r_init_ptr : r_addr;

  always_comb begin
    w_mem_wdata = 13'h0;
    if (r_state == c_st_write) w_mem_wdata = f_encode(r_wdata) ^ r_mask;
    else if (r_state == c_st_fix) w_mem_wdata = w_fixed;
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
    if (r_state == c_st_read) r_rdword <= r_mem[r_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_st_init;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_scrub      <= 1'b0;
      r_init_ptr   <= '0;
      r_scrub_ptr  <= '0;
      r_timer      <= c_tmr_reload;
      r_init_done  <= 1'b0;
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
      r_err_addr   <= '0;
      r_err_irq    <= 1'b0;
      r_rdata      <= '0;
      r_status     <= '0;
      r_mask       <= '0;
    end else begin
      r_err_irq <= 1'b0;
      case (r_state)
        c_st_init: begin
          r_init_ptr <= r_init_ptr + 1'b1;
          if (&r_init_ptr) begin
            r_init_done <= 1'b1;
            r_state     <= c_st_idle;
          end
        end
        c_st_idle: begin
          if (scrub_en && (r_timer != '0)) r_timer <= r_timer - 1'b1;
          if (req_valid) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_scrub <= 1'b0;
`ifdef ECC_ERR_INJECT_EN
            r_mask  <= inj_mask;
`else
            r_mask  <= '0;
`endif
            r_state <= req_we ? c_st_write : c_st_read;
          end else if (scrub_en && (r_timer == '0)) begin
            r_addr  <= r_scrub_ptr;
            r_scrub <= 1'b1;
            r_state <= c_st_read;
          end
        end
        c_st_write: begin
          r_rdata  <= '0;
          r_status <= 2'b00;
          r_state  <= c_st_resp;
        end
        c_st_read: r_state <= c_st_check;
        c_st_check: begin
          r_rdata  <= f_data(w_fixed);
          r_status <= w_uncorr ? 2'b10 : (w_corr ? 2'b01 : 2'b00);
          if (w_corr) begin
            if (r_corr_cnt != '1) r_corr_cnt <= r_corr_cnt + 1'b1;
            r_state <= c_st_fix;
          end else begin
            if (w_uncorr) begin
              if (r_uncorr_cnt != '1) r_uncorr_cnt <= r_uncorr_cnt + 1'b1;
              r_err_addr <= r_addr;
              r_err_irq  <= 1'b1;
            end
            if (r_scrub) begin
              r_scrub_ptr <= r_scrub_ptr + 1'b1;
              r_timer     <= c_tmr_reload;
              r_state     <= c_st_idle;
            end else begin
              r_state <= c_st_resp;
            end
          end
        end
        c_st_fix: begin
          if (r_scrub) begin
            r_scrub_ptr <= r_scrub_ptr + 1'b1;
            r_timer     <= c_tmr_reload;
            r_state     <= c_st_idle;
          end else begin
            r_state <= c_st_resp;
          end
        end
        c_st_resp: r_state <= c_st_idle;
        default:   r_state <= c_st_init;
      endcase
    end
  end

  assign req_ready   = (r_state == c_st_idle);
  assign resp_valid  = (r_state == c_st_resp);
  assign resp_rdata  = resp_valid ? r_rdata : 8'h00;
  assign resp_status = resp_valid ? r_status : 2'b00;
  assign init_done   = r_init_done;
  assign corr_cnt    = r_corr_cnt;
  assign uncorr_cnt  = r_uncorr_cnt;
  assign err_addr    = r_err_addr;
  assign err_irq     = r_err_irq;

endmodule
`default_nettype wire

// File: tb/tb_ecc_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_ecc_mem_ctrl
// Brief   : Directed self-checking bench for ecc_mem_ctrl (ADDR_W=4,
//           SCRUB_INTERVAL=4); injection steps need ECC_ERR_INJECT_EN.
// Revision: 1.0
// ============================================================================
module tb_ecc_mem_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic [12:0] inj_mask;
  logic       resp_valid;
  logic [7:0] resp_rdata;
  logic [1:0] resp_status;
  logic       scrub_en;
  logic       init_done;
  logic [7:0] corr_cnt;
  logic [7:0] uncorr_cnt;
  logic [3:0] err_addr;
  logic       err_irq;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int irq_cnt = 0;
  logic [7:0] got_rdata;
  logic [1:0] got_status;

  ecc_mem_ctrl #(.ADDR_W(4), .SCRUB_INTERVAL(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef ECC_ERR_INJECT_EN
    .inj_mask(inj_mask),
`endif
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_status(resp_status),
    .scrub_en(scrub_en), .init_done(init_done),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt),
    .err_addr(err_addr), .err_irq(err_irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (err_irq) irq_cnt <= irq_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic host(input logic we, input logic [3:0] addr, input logic [7:0] wd, output int lat);
    int t0;
    int n;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 100) begin
      step(1);
      n++;
    end
    if (!req_ready) check("accept_timeout", {31'd0, req_ready}, 32'd1);
    t0 = cyc;
    step(1);
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 100) begin
      step(1);
      n++;
    end
    if (!resp_valid) check("resp_timeout", {31'd0, resp_valid}, 32'd1);
    lat        = cyc - t0;
    got_rdata  = resp_rdata;
    got_status = resp_status;
  endtask

  initial begin
    int lat;
    int n;
    int irq0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; inj_mask = '0; scrub_en = 1'b0;
    step(3);
    check("reset_ctrl", {28'd0, req_ready, resp_valid, init_done, err_irq}, 32'd0);
    check("reset_data", {corr_cnt, uncorr_cnt, err_addr, resp_status, resp_rdata}, 32'd0);

    // Test 1: initialisation then clean read
    rst_n = 1'b1;
    n = 0;
    while (!init_done && n < 100) begin
      step(1);
      n++;
      if (n == 8) check("ready_in_init", {31'd0, req_ready}, 32'd0);
    end
    check("init_cycles", n, 32'd16);
    check("ready_after_init", {31'd0, req_ready}, 32'd1);
    host(1'b0, 4'd3, 8'h00, lat);
    check("t1_rdata", got_rdata, 32'h00);
    check("t1_status", got_status, 32'd0);
    check("t1_lat", lat, 32'd3);

    // Test 2: clean write / read
    host(1'b1, 4'd5, 8'hA5, lat);
    check("t2_wr_lat", lat, 32'd2);
    check("t2_wr_rdata", got_rdata, 32'h00);
    check("t2_mem5", dut.r_mem[5], 32'h0A27);
    host(1'b0, 4'd5, 8'h00, lat);
    check("t2_rdata", got_rdata, 32'hA5);
    check("t2_status", got_status, 32'd0);
    check("t2_lat", lat, 32'd3);

`ifdef ECC_ERR_INJECT_EN
    // Test 3: single-bit error corrected and written back
    inj_mask = 13'h0010;
    host(1'b1, 4'd5, 8'hA5, lat);
    inj_mask = 13'h0000;
    host(1'b0, 4'd5, 8'h00, lat);
    check("t3_rdata", got_rdata, 32'hA5);
    check("t3_status", got_status, 32'd1);
    check("t3_lat", lat, 32'd4);
    check("t3_corr_cnt", corr_cnt, 32'd1);
    host(1'b0, 4'd5, 8'h00, lat);
    check("t3_reread_status", got_status, 32'd0);
    check("t3_reread_lat", lat, 32'd3);
    check("t3_mem5", dut.r_mem[5], 32'h0A27);

    // Test 4: double-bit error (bits 0 and 4 -> raw data A7)
    inj_mask = 13'h0011;
    host(1'b1, 4'd5, 8'hA5, lat);
    inj_mask = 13'h0000;
    irq0 = irq_cnt;
    host(1'b0, 4'd5, 8'h00, lat);
    check("t4_status", got_status, 32'd2);
    check("t4_rdata", got_rdata, 32'hA7);
    check("t4_lat", lat, 32'd3);
    check("t4_uncorr_cnt", uncorr_cnt, 32'd1);
    check("t4_err_addr", err_addr, 32'd5);
    step(2);
    check("t4_irq_pulses", irq_cnt - irq0, 32'd1);
    check("t4_corr_cnt", corr_cnt, 32'd1);

    // Restore addr 5; plant parity-bit errors at addr 0 and 2 for the scrubber
    host(1'b1, 4'd5, 8'hA5, lat);
    inj_mask = 13'h1000;
    host(1'b1, 4'd0, 8'h00, lat);
    host(1'b1, 4'd2, 8'h3C, lat);
    inj_mask = 13'h0000;
`endif

    // Test 6: host request on the cycle the scrub timer reaches 0
    step(1);
    scrub_en = 1'b1;
    step(4);
    host(1'b0, 4'd3, 8'h00, lat);
    check("t6_host_lat", lat, 32'd3);
    check("t6_host_status", got_status, 32'd0);
`ifdef ECC_ERR_INJECT_EN
    check("t6_no_scrub_yet", corr_cnt, 32'd1);
`endif
    step(1);
    check("t6_idle_ready", {31'd0, req_ready}, 32'd1);
    step(1);
    check("t6_scrub_busy", {31'd0, req_ready}, 32'd0);
    step(2);
`ifdef ECC_ERR_INJECT_EN
    check("t6_scrub_fix0", corr_cnt, 32'd2);

    // Test 5: scrubber reaches addr 2 and repairs it
    n = 0;
    while (corr_cnt != 8'd3 && n < 300) begin
      step(1);
      n++;
    end
    check("t5_corr_cnt", corr_cnt, 32'd3);
    scrub_en = 1'b0;
    host(1'b0, 4'd2, 8'h00, lat);
    check("t5_rdata", got_rdata, 32'h3C);
    check("t5_status", got_status, 32'd0);
    host(1'b0, 4'd0, 8'h00, lat);
    check("t5_addr0_status", got_status, 32'd0);
    check("t5_uncorr_cnt", uncorr_cnt, 32'd1);
`endif
    scrub_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
